// File: rtl/acs_pm_array.sv
// Add-compare-select stage of a hard-decision Viterbi decoder: one trellis step per
// accepted branch-metric beat, with a renormalised path-metric bank and best-state report.
module acs_pm_array #(
  parameter int K       = 7,
  parameter int BM_W    = 2,
  parameter int PM_W    = 8,
  parameter int INIT_PM = 64
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          frame_start,
  input  logic                          bm_valid,
  input  logic [(2**(K-1))*BM_W-1:0]    bm0_bus,
  input  logic [(2**(K-1))*BM_W-1:0]    bm1_bus,
  output logic                          dec_valid,
  output logic [(2**(K-1))-1:0]         dec_bits,
  output logic [K-2:0]                  best_state,
  output logic [PM_W-1:0]               best_metric,
  output logic                          norm_evt
);

  localparam int NS = 2**(K-1);
  localparam int SW = K-1;

  typedef logic [PM_W-1:0] pm_t;

  pm_t             pm_q   [NS];
  pm_t             pm_d   [NS];
  logic [NS-1:0]   dec_d;
  logic [SW-1:0]   best_state_d;
  pm_t             best_metric_d;
  logic            norm_d;

  function automatic pm_t reset_pm(input logic [SW-1:0] idx);
    return (idx == '0) ? '0 : pm_t'(INIT_PM);
  endfunction

  // NOTE: every variable assigned in this block gets a default first so no latch is inferred.
  always_comb begin
    pm_t           sel [NS];
    pm_t           pa, pb, s0, s1;
    logic [SW-1:0] n_s, p0, p1;
    logic          all_msb;

    dec_d         = '0;
    all_msb       = 1'b1;
    best_state_d  = '0;
    best_metric_d = '0;
    pa = '0; pb = '0; s0 = '0; s1 = '0;
    n_s = '0; p0 = '0; p1 = '0;

    for (int n = 0; n < NS; n++) begin
      n_s = SW'(n);
      p0  = {1'b0, n_s[SW-1:1]};
      p1  = {1'b1, n_s[SW-1:1]};
      pa  = frame_start ? reset_pm(p0) : pm_q[p0];
      pb  = frame_start ? reset_pm(p1) : pm_q[p1];
      s0  = pa + pm_t'(bm0_bus[n*BM_W +: BM_W]);
      s1  = pb + pm_t'(bm1_bus[n*BM_W +: BM_W]);
      // Ties keep the p0 branch.
      dec_d[n] = (s1 < s0);
      sel[n]   = dec_d[n] ? s1 : s0;
      all_msb  = all_msb & sel[n][PM_W-1];
    end

    norm_d = all_msb;

    for (int n = 0; n < NS; n++) begin
      pm_d[n] = sel[n];
      if (all_msb) pm_d[n][PM_W-1] = 1'b0;
    end

    // Ascending scan with strict compare so ties resolve to the lowest index.
    best_metric_d = pm_d[0];
    for (int n = 1; n < NS; n++) begin
      if (pm_d[n] < best_metric_d) begin
        best_metric_d = pm_d[n];
        best_state_d  = SW'(n);
      end
    end
  end

  // NOTE: the metric bank is a register file that must start from known metrics, so it is reset
  // explicitly; sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int n = 0; n < NS; n++) pm_q[n] <= reset_pm(SW'(n));
      dec_valid   <= 1'b0;
      dec_bits    <= '0;
      best_state  <= '0;
      best_metric <= '0;
      norm_evt    <= 1'b0;
    end else begin
      dec_valid <= bm_valid;
      if (bm_valid) begin
        for (int n = 0; n < NS; n++) pm_q[n] <= pm_d[n];
        dec_bits    <= dec_d;
        best_state  <= best_state_d;
        best_metric <= best_metric_d;
        norm_evt    <= norm_d;
      end
    end
  end

endmodule

// File: tb/tb_acs_pm_array.sv
// Self-checking bench for acs_pm_array: directed scenarios plus random steps scored against
// a trellis model that enumerates source states and input bits.
module tb_acs_pm_array;

  localparam int K    = 7;
  localparam int NS   = 64;
  localparam int BM_W = 2;
  localparam int PM_W = 8;

  logic                 clk = 1'b0;
  logic                 rst = 1'b0;
  logic                 frame_start = 1'b0;
  logic                 bm_valid = 1'b0;
  logic [NS*BM_W-1:0]   bm0_bus = '0;
  logic [NS*BM_W-1:0]   bm1_bus = '0;
  logic                 dec_valid;
  logic [NS-1:0]        dec_bits;
  logic [K-2:0]         best_state;
  logic [PM_W-1:0]      best_metric;
  logic                 norm_evt;

  acs_pm_array #(.K(K), .BM_W(BM_W), .PM_W(PM_W), .INIT_PM(64)) dut (
    .clk(clk), .rst(rst), .frame_start(frame_start), .bm_valid(bm_valid),
    .bm0_bus(bm0_bus), .bm1_bus(bm1_bus), .dec_valid(dec_valid), .dec_bits(dec_bits),
    .best_state(best_state), .best_metric(best_metric), .norm_evt(norm_evt)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  int pm_m [NS];
  int bm0_v [NS];
  int bm1_v [NS];
  logic [NS-1:0] exp_dec = '0;
  int exp_bs = 0, exp_bm = 0;
  bit exp_norm = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int s = 0; s < NS; s++) pm_m[s] = (s == 0) ? 0 : 64;
  endtask

  // Expand every (source, input bit) edge; the edge from a source with MSB 0 carries bm0.
  task automatic model_step(input bit fs);
    int src [NS];
    int c0 [NS];
    int c1 [NS];
    int nw [NS];
    bit all_hi;
    for (int s = 0; s < NS; s++) src[s] = fs ? ((s == 0) ? 0 : 64) : pm_m[s];
    for (int s = 0; s < NS; s++)
      for (int u = 0; u < 2; u++) begin
        int d;
        d = (s * 2 + u) % NS;
        if (s < NS / 2) c0[d] = src[s] + bm0_v[d];
        else            c1[d] = src[s] + bm1_v[d];
      end
    all_hi = 1;
    for (int d = 0; d < NS; d++) begin
      exp_dec[d] = (c1[d] < c0[d]);
      nw[d] = exp_dec[d] ? c1[d] : c0[d];
      if (nw[d] < 128) all_hi = 0;
    end
    exp_norm = all_hi;
    exp_bm = 1 << 30;
    for (int d = 0; d < NS; d++) begin
      pm_m[d] = all_hi ? nw[d] - 128 : nw[d];
      if (pm_m[d] < exp_bm) begin
        exp_bm = pm_m[d];
        exp_bs = d;
      end
    end
  endtask

  task automatic load_bus();
    for (int n = 0; n < NS; n++) begin
      bm0_bus[n*BM_W +: BM_W] = BM_W'(bm0_v[n]);
      bm1_bus[n*BM_W +: BM_W] = BM_W'(bm1_v[n]);
    end
  endtask

  task automatic fill_const(input int a, input int b);
    for (int n = 0; n < NS; n++) begin
      bm0_v[n] = a;
      bm1_v[n] = b;
    end
  endtask

  task automatic fill_rand();
    for (int n = 0; n < NS; n++) begin
      bm0_v[n] = int'($urandom_range(2, 0));
      bm1_v[n] = int'($urandom_range(2, 0));
    end
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".valid"}, 64'(dec_valid), 64'(1));
    check({tag, ".dec"}, 64'(dec_bits), 64'(exp_dec));
    check({tag, ".bstate"}, 64'(best_state), 64'(exp_bs));
    check({tag, ".bmetric"}, 64'(best_metric), 64'(exp_bm));
    check({tag, ".norm"}, 64'(norm_evt), 64'(exp_norm));
  endtask

  task automatic do_step(input string tag, input bit fs, input bit chk);
    @(negedge clk);
    load_bus();
    frame_start = fs;
    bm_valid = 1'b1;
    model_step(fs);
    @(posedge clk);
    #1;
    if (chk) check_outputs(tag);
  endtask

  task automatic do_idle(input string tag, input bit fs);
    @(negedge clk);
    bm_valid = 1'b0;
    frame_start = fs;
    fill_rand();
    load_bus();
    @(posedge clk);
    #1;
    check({tag, ".valid"}, 64'(dec_valid), 64'(0));
    check({tag, ".hold"}, 64'(dec_bits), 64'(exp_dec));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bm_valid = 1'b0;
    frame_start = 1'b0;
    @(posedge clk);
    #1;
    check("rst.valid", 64'(dec_valid), 64'(0));
    check("rst.dec", 64'(dec_bits), 64'(0));
    check("rst.bstate", 64'(best_state), 64'(0));
    check("rst.bmetric", 64'(best_metric), 64'(0));
    check("rst.norm", 64'(norm_evt), 64'(0));
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    exp_dec = '0;
  endtask

  initial begin
    // Scenario 1: zero metrics straight after reset.
    do_reset();
    fill_const(0, 0);
    do_step("s1", 1'b0, 1'b1);
    check("s1.dec_const", 64'(dec_bits), 64'(0));
    check("s1.bm_const", 64'(best_metric), 64'(0));

    // Scenario 2: bm0=2, bm1=0 everywhere.
    do_reset();
    fill_const(2, 0);
    do_step("s2", 1'b0, 1'b1);
    check("s2.dec0", 64'(dec_bits[0]), 64'(0));
    check("s2.dec1", 64'(dec_bits[1]), 64'(0));
    check("s2.dec2", 64'(dec_bits[2]), 64'(1));
    check("s2.bm_const", 64'(best_metric), 64'(2));
    check("s2.bs_const", 64'(best_state), 64'(0));

    // Scenario 3: random run with a 10-cycle gap (and an ignored frame_start) mid-stream.
    for (int i = 0; i < 8; i++) begin
      fill_rand();
      do_step("s3a", 1'b0, 1'b1);
    end
    for (int i = 0; i < 10; i++) do_idle("s3gap", (i == 4));
    for (int i = 0; i < 8; i++) begin
      fill_rand();
      do_step("s3b", 1'b0, 1'b1);
    end

    // Scenario 4: 128 unit-metric steps from reset, normalisation on the last.
    do_reset();
    fill_const(1, 1);
    for (int i = 1; i <= 128; i++) begin
      do_step("s4", 1'b0, 1'b1);
      if (i == 127) check("s4.bm127", 64'(best_metric), 64'(127));
    end
    check("s4.norm128", 64'(norm_evt), 64'(1));
    check("s4.bm128", 64'(best_metric), 64'(0));
    fill_const(0, 0);
    do_step("s4post", 1'b0, 1'b1);
    check("s4post.bm", 64'(best_metric), 64'(0));

    // Scenario 5: 20 random steps, then frame_start with zero metrics.
    for (int i = 0; i < 20; i++) begin
      fill_rand();
      do_step("s5r", 1'b0, 1'b1);
    end
    fill_const(0, 0);
    do_step("s5", 1'b1, 1'b1);
    check("s5.dec_const", 64'(dec_bits), 64'(0));
    check("s5.bm_const", 64'(best_metric), 64'(0));
    check("s5.bs_const", 64'(best_state), 64'(0));
    check("s5.norm_const", 64'(norm_evt), 64'(0));

    // Scenario 6: reset coincident with a valid step discards it.
    for (int i = 0; i < 5; i++) begin
      fill_rand();
      do_step("s6r", 1'b0, 1'b1);
    end
    @(negedge clk);
    rst = 1'b1;
    bm_valid = 1'b1;
    fill_rand();
    load_bus();
    @(posedge clk);
    #1;
    check("s6.valid", 64'(dec_valid), 64'(0));
    check("s6.dec", 64'(dec_bits), 64'(0));
    @(negedge clk);
    rst = 1'b0;
    bm_valid = 1'b0;
    model_reset();
    fill_const(0, 0);
    do_step("s6post", 1'b0, 1'b1);
    check("s6post.bm", 64'(best_metric), 64'(0));

    @(negedge clk);
    bm_valid = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
